hazard_fwd_unit: RTL and testbench

- Parametrised interlock and forwarding unit for the five-stage integer/FP pipeline, sitting beside the ID-stage decoder.
- Tracks in-flight destination registers over FWD_DEPTH downstream stages.
- Produces per-source forwarding selects, load-use and branch-operand stalls, and sequences multi-cycle (multiply-class) operations with a configurable latency.
- Generalises the fixed two-stage, two-source, four-cycle hazard logic to arbitrary depth, source count and latency, and adds flush handling.

---
 rtl/hazard_pkg.sv | 32 +++
 rtl/hazard_fwd_unit_mc_sequencer.sv | 70 +++++++
 rtl/hazard_fwd_unit.sv | 145 ++++++++++++++
 tb/tb_hazard_fwd_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// ============================================================================
// Module : hazard_pkg
// Brief  : Shared types and constants for the hazard/forwarding unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    // Widest register address any instance may use; narrower ones zero-extend.
    localparam int C_MAX_REG_ADDR_W = 8;
    localparam logic [C_MAX_REG_ADDR_W-1:0] C_REG_ZERO = '0;

    typedef struct packed {
        logic                        valid;
        logic [C_MAX_REG_ADDR_W-1:0] rd;
        logic                        is_load;
    } track_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    function automatic int fwd_sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_fwd_unit_mc_sequencer.sv
// ============================================================================
// Module : mc_sequencer
// Brief  : Holds a multi-cycle op in ID for exactly MC_LATENCY cycles.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_sequencer
    import hazard_pkg::*;
#(
    parameter int MC_LATENCY = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic flush,
    output logic stall_mc,
    output logic busy,
    output logic done
);

    localparam int               C_CNT_W    = $clog2(MC_LATENCY);
    localparam logic [C_CNT_W-1:0] C_CNT_LOAD = C_CNT_W'(MC_LATENCY - 2);
    // With a latency of 2 the start cycle is followed directly by the result.
    localparam mc_state_t        C_START_NEXT = (MC_LATENCY == 2) ? DONE : BUSY;

    mc_state_t          r_state;
    logic [C_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= C_START_NEXT;
                        r_count <= C_CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        r_state <= IDLE;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count - C_CNT_W'(1);
                        if (r_count <= C_CNT_W'(1)) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE) & ~flush;
    assign stall_mc = ((r_state == IDLE) & start) | ((r_state == BUSY) & ~flush);

endmodule

`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
// ============================================================================
// Module : hazard_fwd_unit
// Brief  : ID-stage interlock/forwarding unit; HAZARD_STATS_EN adds counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter  int REG_ADDR_W = 5,
    parameter  int NUM_SRC    = 2,
    parameter  int FWD_DEPTH  = 2,
    parameter  int MC_LATENCY = 4,
    localparam int SEL_W      = fwd_sel_width(FWD_DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]            id_rs_used,
    input  logic [REG_ADDR_W-1:0]         id_rd,
    input  logic                          id_reg_wr,
    input  logic                          id_is_load,
    input  logic                          id_is_branch,
    input  logic                          id_is_mc,
    input  logic                          flush,
    output logic                          stall,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
    output logic                          mc_busy,
    output logic                          mc_done,
    output logic                          mc_wr
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]                   stall_cycles,
    output logic [31:0]                   fwd_hits
`endif
);

    track_entry_t r_entry [FWD_DEPTH];
    track_entry_t w_newEntry;

    logic                        w_live;
    logic                        w_haz;
    logic                        w_stallMc;
    logic [NUM_SRC-1:0]          w_m0;
    logic [NUM_SRC-1:0]          w_m1;
    logic [C_MAX_REG_ADDR_W-1:0] w_rdExt;

    assign w_live  = id_valid & ~flush;
    assign w_rdExt = C_MAX_REG_ADDR_W'(id_rd);

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [C_MAX_REG_ADDR_W-1:0] w_rs;
        logic [FWD_DEPTH-1:0]        w_match;
        logic [SEL_W-1:0]            w_sel;

        assign w_rs = C_MAX_REG_ADDR_W'(id_rs[i*REG_ADDR_W +: REG_ADDR_W]);

        always_comb begin
            for (int k = 0; k < FWD_DEPTH; k++) begin
                w_match[k] = id_rs_used[i] & r_entry[k].valid &
                             (w_rs == r_entry[k].rd) & (w_rs != C_REG_ZERO);
            end
        end

        // Scan oldest to youngest so the youngest producer overrides.
        always_comb begin
            w_sel = '0;
            for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
                if (w_match[k]) begin
                    w_sel = SEL_W'(k + 1);
                end
            end
        end

        assign fwd_sel[i*SEL_W +: SEL_W] = w_live ? w_sel : '0;
        assign w_m0[i] = w_match[0];
        assign w_m1[i] = w_match[1];
    end

    assign w_haz = w_live & (((|w_m0) & r_entry[0].is_load) |
                             (id_is_branch & (|w_m0)) |
                             (id_is_branch & (|w_m1) & r_entry[1].is_load));

    mc_sequencer #(
        .MC_LATENCY (MC_LATENCY)
    ) u_mc_sequencer (
        .clk      (clk),
        .reset    (reset),
        .start    (w_live & id_is_mc & ~w_haz),
        .flush    (flush),
        .stall_mc (w_stallMc),
        .busy     (mc_busy),
        .done     (mc_done)
    );

    assign stall = w_live & (w_haz | w_stallMc);
    assign mc_wr = mc_done;

    always_comb begin
        w_newEntry         = '0;
        w_newEntry.valid   = w_live & id_reg_wr & (w_rdExt != C_REG_ZERO);
        w_newEntry.rd      = w_rdExt;
        w_newEntry.is_load = id_is_load;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < FWD_DEPTH; k++) begin
                r_entry[k] <= '0;
            end
        end else begin
            r_entry[0] <= stall ? '0 : w_newEntry;
            for (int k = 1; k < FWD_DEPTH; k++) begin
                r_entry[k] <= r_entry[k-1];
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stallCycles;
    logic [31:0] r_fwdHits;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCycles <= '0;
            r_fwdHits     <= '0;
        end else begin
            if (stall && (r_stallCycles != 32'hFFFF_FFFF)) begin
                r_stallCycles <= r_stallCycles + 32'd1;
            end
            if ((|fwd_sel) && (r_fwdHits != 32'hFFFF_FFFF)) begin
                r_fwdHits <= r_fwdHits + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stallCycles;
    assign fwd_hits     = r_fwdHits;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
// ============================================================================
// Module : tb_hazard_fwd_unit
// Brief  : Self-checking bench: directed vector table, multi-cycle sequences,
//          and randomized traffic against a queue-based reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_fwd_unit;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [9:0] id_rs;
    logic [1:0] id_rs_used;
    logic [4:0] id_rd;
    logic       id_reg_wr, id_is_load, id_is_branch, id_is_mc, flush;

    logic       stall4, busy4, done4, wr4;
    logic [3:0] sel4;
    logic       stall6, busy6, done6, wr6;
    logic [3:0] sel6;
`ifdef HAZARD_STATS_EN
    logic [31:0] sc4, fh4, sc6, fh6;
`endif

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .FWD_DEPTH(2), .MC_LATENCY(LAT)) dut4 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_reg_wr(id_reg_wr),
        .id_is_load(id_is_load), .id_is_branch(id_is_branch), .id_is_mc(id_is_mc),
        .flush(flush), .stall(stall4), .fwd_sel(sel4), .mc_busy(busy4),
        .mc_done(done4), .mc_wr(wr4)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(sc4), .fwd_hits(fh4)
`endif
    );

    hazard_fwd_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .FWD_DEPTH(2), .MC_LATENCY(6)) dut6 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_reg_wr(id_reg_wr),
        .id_is_load(id_is_load), .id_is_branch(id_is_branch), .id_is_mc(id_is_mc),
        .flush(flush), .stall(stall6), .fwd_sel(sel6), .mc_busy(busy6),
        .mc_done(done6), .mc_wr(wr6)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(sc6), .fwd_hits(fh6)
`endif
    );

    typedef struct {
        logic       v;
        logic [4:0] rs0, rs1;
        logic [1:0] used;
        logic [4:0] rd;
        logic       wr, ld, br, fl;
        logic       expStall;
        logic [1:0] expSel0, expSel1;
    } vec_t;

    typedef struct {
        bit v;
        int rd;
        bit ld;
    } prod_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic setIn(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [1:0] used, input logic [4:0] rd, input logic wr,
                         input logic ld, input logic br, input logic mc, input logic fl);
        id_valid = v; id_rs = {rs1, rs0}; id_rs_used = used; id_rd = rd;
        id_reg_wr = wr; id_is_load = ld; id_is_branch = br; id_is_mc = mc; flush = fl;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    vec_t tbl[25];

    initial begin
        prod_t pipeQ[$];
        prod_t dummy;
        int    age;

        // v rs0 rs1 used rd wr ld br fl | stall sel0 sel1
        tbl[0]  = '{1, 1,  2, 3, 3,  1, 0, 0, 0, 0, 0, 0};  // ADD r3
        tbl[1]  = '{1, 3,  5, 3, 4,  1, 0, 0, 0, 0, 1, 0};  // ADD r4,r3,r5
        tbl[2]  = '{0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0};  // NOP
        tbl[3]  = '{1, 4,  0, 3, 11, 1, 0, 0, 0, 0, 2, 0};  // r4 one NOP back
        tbl[4]  = '{1, 1,  0, 1, 7,  1, 1, 0, 0, 0, 0, 0};  // LW r7
        tbl[5]  = '{1, 7,  7, 3, 8,  1, 0, 0, 0, 1, 1, 1};  // load-use stall
        tbl[6]  = '{1, 7,  7, 3, 8,  1, 0, 0, 0, 0, 2, 2};
        tbl[7]  = '{1, 1,  1, 3, 0,  1, 0, 0, 0, 0, 0, 0};  // ADD r0
        tbl[8]  = '{1, 0,  0, 3, 1,  1, 0, 0, 0, 0, 0, 0};  // reads r0
        tbl[9]  = '{1, 5,  5, 3, 2,  1, 0, 0, 0, 0, 0, 0};  // ADD r2
        tbl[10] = '{1, 2,  2, 0, 12, 1, 0, 0, 0, 0, 0, 0};  // r2 not used
        tbl[11] = '{1, 1,  1, 3, 9,  1, 0, 0, 0, 0, 0, 0};  // ADD r9
        tbl[12] = '{1, 9,  0, 1, 0,  0, 0, 1, 0, 1, 1, 0};  // BEQZ r9
        tbl[13] = '{1, 9,  0, 1, 0,  0, 0, 1, 0, 0, 2, 0};
        tbl[14] = '{1, 1,  0, 1, 9,  1, 1, 0, 0, 0, 0, 0};  // LW r9
        tbl[15] = '{1, 9,  0, 1, 0,  0, 0, 1, 0, 1, 1, 0};  // BEQZ after LW
        tbl[16] = '{1, 9,  0, 1, 0,  0, 0, 1, 0, 1, 2, 0};
        tbl[17] = '{1, 9,  0, 1, 0,  0, 0, 1, 0, 0, 0, 0};
        tbl[18] = '{1, 1,  1, 3, 13, 1, 0, 0, 0, 0, 0, 0};  // ADD r13
        tbl[19] = '{1, 13, 0, 1, 14, 1, 0, 0, 1, 0, 0, 0};  // flushed
        tbl[20] = '{1, 13, 0, 1, 0,  0, 0, 0, 0, 0, 2, 0};
        tbl[21] = '{1, 14, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0};  // flushed r14 never tracked
        tbl[22] = '{1, 1,  0, 1, 7,  1, 1, 0, 0, 0, 0, 0};  // LW r7
        tbl[23] = '{1, 7,  0, 1, 0,  0, 0, 0, 1, 0, 0, 0};  // flush masks load-use
        tbl[24] = '{1, 7,  0, 1, 0,  0, 0, 0, 0, 0, 2, 0};

        // Reset state
        doReset();
        @(negedge clk);
        chk("rst_stall", stall4, 0);
        chk("rst_fwd",   sel4,   0);
        chk("rst_busy",  busy4,  0);
        chk("rst_done",  done4,  0);
        chk("rst_wr",    wr4,    0);
        nextCycle();

        // Directed vector table
        foreach (tbl[r]) begin
            setIn(tbl[r].v, tbl[r].rs0, tbl[r].rs1, tbl[r].used, tbl[r].rd,
                  tbl[r].wr, tbl[r].ld, tbl[r].br, 1'b0, tbl[r].fl);
            @(negedge clk);
            chk($sformatf("vec%0d_stall", r), stall4, tbl[r].expStall);
            chk($sformatf("vec%0d_sel0", r), sel4[1:0], tbl[r].expSel0);
            chk($sformatf("vec%0d_sel1", r), sel4[3:2], tbl[r].expSel1);
            chk($sformatf("vec%0d_busy", r), busy4, 0);
            chk($sformatf("vec%0d_done", r), done4, 0);
            nextCycle();
        end

        // Multi-cycle op, latency 4: 3 stalls then done/wr, result tracked after
        doReset();
        for (int c = 1; c <= 4; c++) begin
            setIn(1, 1, 2, 3, 15, 1, 0, 0, 1, 0);
            @(negedge clk);
            chk($sformatf("mc4_c%0d_stall", c), stall4, (c < 4));
            chk($sformatf("mc4_c%0d_done", c), done4, (c == 4));
            chk($sformatf("mc4_c%0d_wr", c), wr4, (c == 4));
            chk($sformatf("mc4_c%0d_busy", c), busy4, (c >= 2));
            nextCycle();
        end
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("mc4_after_busy", busy4, 0);
        chk("mc4_after_done", done4, 0);
        nextCycle();
        setIn(1, 15, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("mc4_result_fwd", sel4[1:0], 2);
        nextCycle();

        // Multi-cycle op, latency 6: 5 stalls then done/wr
        doReset();
        for (int c = 1; c <= 6; c++) begin
            setIn(1, 1, 2, 3, 15, 1, 0, 0, 1, 0);
            @(negedge clk);
            chk($sformatf("mc6_c%0d_stall", c), stall6, (c < 6));
            chk($sformatf("mc6_c%0d_done", c), done6, (c == 6));
            chk($sformatf("mc6_c%0d_wr", c), wr6, (c == 6));
            nextCycle();
        end
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("mc6_after_busy", busy6, 0);
        nextCycle();

        // Flush in the second BUSY cycle aborts without a completion pulse
        doReset();
        for (int c = 1; c <= 3; c++) begin
            setIn(1, 1, 2, 3, 15, 1, 0, 0, 1, (c == 3));
            @(negedge clk);
            chk($sformatf("mcfl_c%0d_stall", c), stall4, (c < 3));
            chk($sformatf("mcfl_c%0d_done", c), done4, 0);
            nextCycle();
        end
        for (int c = 4; c <= 6; c++) begin
            setIn(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("mcfl_c%0d_busy", c), busy4, 0);
            chk($sformatf("mcfl_c%0d_done", c), done4, 0);
            chk($sformatf("mcfl_c%0d_stall", c), stall4, 0);
            nextCycle();
        end

        // Reset in the middle of a multi-cycle op
        doReset();
        for (int c = 1; c <= 2; c++) begin
            setIn(1, 1, 2, 3, 15, 1, 0, 0, 1, 0);
            nextCycle();
        end
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            setIn(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("mcrst_c%0d_busy", c), busy4, 0);
            chk($sformatf("mcrst_c%0d_done", c), done4, 0);
            chk($sformatf("mcrst_c%0d_stall", c), stall4, 0);
            nextCycle();
        end

        // Randomized traffic against the reference model
        doReset();
        pipeQ = {};
        pipeQ.push_back('{0, 0, 0});
        pipeQ.push_back('{0, 0, 0});
        age = 0;
        for (int n = 0; n < 3000; n++) begin
            logic       v, wr, ld, br, mc, fl;
            logic [4:0] rs[2];
            logic [4:0] rd;
            logic [1:0] used;
            int         sel[2];
            bit         live, m0, m1, haz, expStall;
            int         a;
            prod_t      np;

            v    = ($urandom_range(0, 3) != 0);
            rs[0] = 5'($urandom_range(0, 3));
            rs[1] = 5'($urandom_range(0, 3));
            used = 2'($urandom_range(0, 3));
            rd   = 5'($urandom_range(0, 3));
            wr   = ($urandom_range(0, 3) != 0);
            ld   = ($urandom_range(0, 2) == 0);
            br   = ($urandom_range(0, 3) == 0);
            mc   = ($urandom_range(0, 5) == 0);
            fl   = ($urandom_range(0, 9) == 0);
            setIn(v, rs[0], rs[1], used, rd, wr, ld, br, mc, fl);
            @(negedge clk);

            live = v && !fl;
            m0 = 0;
            m1 = 0;
            for (int i = 0; i < 2; i++) begin
                sel[i] = 0;
                for (int k = 1; k >= 0; k--) begin
                    if (used[i] && pipeQ[k].v && pipeQ[k].rd == int'(rs[i]) && rs[i] != 0) begin
                        sel[i] = k + 1;
                        if (k == 0) m0 = 1;
                        else        m1 = 1;
                    end
                end
            end
            haz = live && ((m0 && pipeQ[0].ld) || (br && m0) || (br && m1 && pipeQ[1].ld));
            a = age;
            if (age == 0 && live && mc && !haz) a = 1;
            expStall = live && (haz || (a >= 1 && a < LAT));

            chk("rnd_stall", stall4, expStall);
            chk("rnd_sel0", sel4[1:0], live ? sel[0] : 0);
            chk("rnd_sel1", sel4[3:2], live ? sel[1] : 0);
            chk("rnd_busy", busy4, (a >= 2));
            chk("rnd_done", done4, (a == LAT) && !fl);
            chk("rnd_wr",   wr4,   (a == LAT) && !fl);

            age = (fl || a == LAT || a == 0) ? 0 : a + 1;
            if (expStall) np = '{0, 0, 0};
            else          np = '{live && wr && rd != 0, int'(rd), ld};
            pipeQ.push_front(np);
            dummy = pipeQ.pop_back();
            nextCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

`default_nettype wire
